// File: rtl/nmea_pkg.sv
// nmea_pkg: shared ASCII constants, parser state encoding and hex-digit decode.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package nmea_pkg;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_FIELDS,
    ST_CK_HI,
    ST_CK_LO,
    ST_WAIT_CR
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] nib;
  } hex_t;

  // Accepts 0-9, A-F and a-f; anything else comes back with vld=0.
  function automatic hex_t hex_decode(input logic [7:0] c);
    hex_t h;
    h.vld = 1'b1;
    h.nib = 4'h0;
    if (c >= 8'h30 && c <= 8'h39)      h.nib = 4'(c - 8'h30);
    else if (c >= 8'h41 && c <= 8'h46) h.nib = 4'(c - 8'h37);
    else if (c >= 8'h61 && c <= 8'h66) h.nib = 4'(c - 8'h57);
    else                               h.vld = 1'b0;
    return h;
  endfunction

endpackage

// File: rtl/nmea_sentence_parser_if.sv
// nmea_sentence_parser_if: byte stream in, published sentence fields and strobes out.
// Latency: n/a (signal bundle only).
// Backpressure: none; in_valid is a one-cycle qualifier per byte.
interface nmea_sentence_parser_if #(
  parameter int NUM_SLOTS     = 4,
  parameter int FIELD_MAX_LEN = 16
);
  logic [7:0]                           in_char;
  logic                                 in_valid;
  logic [31:0]                          field_mask;
  logic [NUM_SLOTS*FIELD_MAX_LEN*8-1:0] fields_vec;
  logic [NUM_SLOTS*8-1:0]               fields_len;
  logic [NUM_SLOTS-1:0]                 trunc_flags;
  logic                                 sent_valid;
  logic                                 err_cksum;
  logic [15:0]                          sent_count;

  modport master (
    output in_char, in_valid, field_mask,
    input  fields_vec, fields_len, trunc_flags, sent_valid, err_cksum, sent_count
  );

  modport slave (
    input  in_char, in_valid, field_mask,
    output fields_vec, fields_len, trunc_flags, sent_valid, err_cksum, sent_count
  );
endinterface

// File: rtl/nmea_field_buffer.sv
// nmea_field_buffer: working slot storage filled per byte, copied to published registers on publish.
// Latency: published registers and pub_vld update one cycle after publish.
// Backpressure: none; writes to slots >= NUM_SLOTS or past FIELD_MAX_LEN are dropped.
module nmea_field_buffer #(
  parameter int NUM_SLOTS     = 4,
  parameter int FIELD_MAX_LEN = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr,
  input  logic                                 wr_en,
  input  logic [7:0]                           wr_slot,
  input  logic [7:0]                           wr_char,
  input  logic                                 publish,
  output logic [NUM_SLOTS*FIELD_MAX_LEN*8-1:0] pub_dat,
  output logic [NUM_SLOTS*8-1:0]               pub_len,
  output logic [NUM_SLOTS-1:0]                 pub_trunc,
  output logic                                 pub_vld
);
  localparam int DW = NUM_SLOTS * FIELD_MAX_LEN * 8;

  logic [DW-1:0]          wk_dat_q, wk_dat_d, pub_dat_q, pub_dat_d;
  logic [NUM_SLOTS*8-1:0] wk_len_q, wk_len_d, pub_len_q, pub_len_d;
  logic [NUM_SLOTS-1:0]   wk_trunc_q, wk_trunc_d, pub_trunc_q, pub_trunc_d;
  logic                   pub_vld_q, pub_vld_d;

  // Append a char to the addressed slot (or flag truncation) and snapshot on publish.
  always_comb begin
    wk_dat_d   = wk_dat_q;
    wk_len_d   = wk_len_q;
    wk_trunc_d = wk_trunc_q;
    if (clr) begin
      wk_dat_d   = '0;
      wk_len_d   = '0;
      wk_trunc_d = '0;
    end else if (wr_en) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (wr_slot == 8'(s)) begin
          if (wk_len_q[s*8 +: 8] == 8'(FIELD_MAX_LEN)) begin
            wk_trunc_d[s] = 1'b1;
          end else begin
            for (int j = 0; j < FIELD_MAX_LEN; j++) begin
              if (wk_len_q[s*8 +: 8] == 8'(j)) wk_dat_d[(s*FIELD_MAX_LEN+j)*8 +: 8] = wr_char;
            end
            wk_len_d[s*8 +: 8] = wk_len_q[s*8 +: 8] + 8'd1;
          end
        end
      end
    end
    pub_dat_d   = publish ? wk_dat_q   : pub_dat_q;
    pub_len_d   = publish ? wk_len_q   : pub_len_q;
    pub_trunc_d = publish ? wk_trunc_q : pub_trunc_q;
    pub_vld_d   = publish;
  end

  // Working and published storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wk_dat_q    <= '0;
      wk_len_q    <= '0;
      wk_trunc_q  <= '0;
      pub_dat_q   <= '0;
      pub_len_q   <= '0;
      pub_trunc_q <= '0;
      pub_vld_q   <= 1'b0;
    end else begin
      wk_dat_q    <= wk_dat_d;
      wk_len_q    <= wk_len_d;
      wk_trunc_q  <= wk_trunc_d;
      pub_dat_q   <= pub_dat_d;
      pub_len_q   <= pub_len_d;
      pub_trunc_q <= pub_trunc_d;
      pub_vld_q   <= pub_vld_d;
    end
  end

  assign pub_dat   = pub_dat_q;
  assign pub_len   = pub_len_q;
  assign pub_trunc = pub_trunc_q;
  assign pub_vld   = pub_vld_q;

endmodule

// File: rtl/nmea_sentence_parser.sv
// nmea_sentence_parser: matches one NMEA sentence type, captures masked fields, publishes atomically.
// Latency: sent_valid / err_cksum one cycle after the CR byte; all outputs registered.
// Backpressure: none, one byte per in_valid pulse. Build option NMEA_CKSUM_EN enables '*hh' verification.
module nmea_sentence_parser #(
  parameter logic [23:0] TYPE_ID       = "RMC",
  parameter int          NUM_SLOTS     = 4,
  parameter int          FIELD_MAX_LEN = 16,
  parameter int          MAX_CHARS     = 82
) (
  input logic                   clk,
  input logic                   rst,
  nmea_sentence_parser_if.slave bus
);
  import nmea_pkg::*;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  addr_idx_q, addr_idx_d;
  logic        type_ok_q, type_ok_d;
  logic [7:0]  field_idx_q, field_idx_d;
  logic [7:0]  slot_q, slot_d;
  logic [31:0] mask_q, mask_d;
  logic [15:0] sent_count_q, sent_count_d;
`ifdef NMEA_CKSUM_EN
  logic [7:0]  cksum_q, cksum_d;
  logic [7:0]  rx_ck_q, rx_ck_d;
  logic        err_cksum_q, err_cksum_d;
  hex_t        hex;
`endif

  logic       is_dollar, is_comma, is_star, is_cr, ovf, field_masked;
  logic [7:0] type_char;
  logic       buf_clr, buf_wr, pub_d;

  assign is_dollar    = bus.in_char == CH_DOLLAR;
  assign is_comma     = bus.in_char == CH_COMMA;
  assign is_star      = bus.in_char == CH_STAR;
  assign is_cr        = bus.in_char == CH_CR;
  // The incoming byte would be one past the sentence length limit.
  assign ovf          = cnt_q >= 8'(MAX_CHARS);
  assign field_masked = (field_idx_q < 8'd32) && mask_q[field_idx_q[4:0]];
  assign type_char    = (addr_idx_q == 3'd2) ? TYPE_ID[23:16] :
                        (addr_idx_q == 3'd3) ? TYPE_ID[15:8] : TYPE_ID[7:0];
  assign sent_count_d = sent_count_q + {15'd0, pub_d};
`ifdef NMEA_CKSUM_EN
  assign hex = hex_decode(bus.in_char);
`endif

  // State register plus per-sentence context; reset drops any sentence in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_idx_q   <= '0;
      type_ok_q    <= 1'b0;
      field_idx_q  <= '0;
      slot_q       <= '0;
      mask_q       <= '0;
      sent_count_q <= '0;
`ifdef NMEA_CKSUM_EN
      cksum_q      <= '0;
      rx_ck_q      <= '0;
      err_cksum_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_idx_q   <= addr_idx_d;
      type_ok_q    <= type_ok_d;
      field_idx_q  <= field_idx_d;
      slot_q       <= slot_d;
      mask_q       <= mask_d;
      sent_count_q <= sent_count_d;
`ifdef NMEA_CKSUM_EN
      cksum_q      <= cksum_d;
      rx_ck_q      <= rx_ck_d;
      err_cksum_q  <= err_cksum_d;
`endif
    end
  end

  // Next state and sentence context; '$' restarts from any state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_idx_d  = addr_idx_q;
    type_ok_d   = type_ok_q;
    field_idx_d = field_idx_q;
    slot_d      = slot_q;
    mask_d      = mask_q;
`ifdef NMEA_CKSUM_EN
    cksum_d     = cksum_q;
    rx_ck_d     = rx_ck_q;
`endif
    if (bus.in_valid) begin
      if (is_dollar) begin
        state_d     = ST_ADDR;
        cnt_d       = 8'd1;
        addr_idx_d  = '0;
        type_ok_d   = 1'b1;
        field_idx_d = '0;
        slot_d      = '0;
        mask_d      = bus.field_mask;
`ifdef NMEA_CKSUM_EN
        cksum_d     = '0;
`endif
      end else if (state_q != ST_IDLE) begin
        if (ovf) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          case (state_q)
            ST_ADDR: begin
`ifdef NMEA_CKSUM_EN
              cksum_d = cksum_q ^ bus.in_char;
`endif
              if (is_comma) begin
                if (addr_idx_q == 3'd5 && type_ok_q) begin
                  state_d     = ST_FIELDS;
                  field_idx_d = 8'd1;
                  slot_d      = slot_q + {7'd0, field_masked};
                end else begin
                  state_d = ST_IDLE;
                end
              end else begin
                // An address longer than five chars can never match.
                if (addr_idx_q == 3'd5) type_ok_d = 1'b0;
                else                    addr_idx_d = addr_idx_q + 3'd1;
                if (addr_idx_q >= 3'd2 && addr_idx_q <= 3'd4 && bus.in_char != type_char)
                  type_ok_d = 1'b0;
              end
            end
            ST_FIELDS: begin
              if (is_star) begin
`ifdef NMEA_CKSUM_EN
                state_d = ST_CK_HI;
`else
                state_d = ST_WAIT_CR;
`endif
              end else if (is_cr) begin
                state_d = ST_IDLE;
              end else begin
`ifdef NMEA_CKSUM_EN
                cksum_d = cksum_q ^ bus.in_char;
`endif
                if (is_comma) begin
                  field_idx_d = field_idx_q + 8'd1;
                  slot_d      = slot_q + {7'd0, field_masked};
                end
              end
            end
`ifdef NMEA_CKSUM_EN
            ST_CK_HI: begin
              rx_ck_d[7:4] = hex.nib;
              state_d      = hex.vld ? ST_CK_LO : ST_IDLE;
            end
            ST_CK_LO: begin
              rx_ck_d[3:0] = hex.nib;
              state_d      = hex.vld ? ST_WAIT_CR : ST_IDLE;
            end
`endif
            ST_WAIT_CR: if (is_cr) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
          endcase
        end
      end
    end
  end

  // Buffer controls and result strobes for the current byte.
  always_comb begin
    buf_clr = bus.in_valid && is_dollar;
    buf_wr  = 1'b0;
    pub_d   = 1'b0;
`ifdef NMEA_CKSUM_EN
    err_cksum_d = 1'b0;
`endif
    if (bus.in_valid && !is_dollar && state_q != ST_IDLE && !ovf) begin
      case (state_q)
        ST_ADDR:   buf_wr = !is_comma && field_masked;
        ST_FIELDS: begin
          buf_wr = !is_comma && !is_star && !is_cr && field_masked;
`ifdef NMEA_CKSUM_EN
          err_cksum_d = is_cr;
`else
          pub_d = is_cr;
`endif
        end
`ifdef NMEA_CKSUM_EN
        ST_CK_HI, ST_CK_LO: err_cksum_d = !hex.vld;
        ST_WAIT_CR: begin
          pub_d       = is_cr && (rx_ck_q == cksum_q);
          err_cksum_d = is_cr && (rx_ck_q != cksum_q);
        end
`else
        ST_WAIT_CR: pub_d = is_cr;
`endif
        default: ;
      endcase
    end
  end

  nmea_field_buffer #(
    .NUM_SLOTS     (NUM_SLOTS),
    .FIELD_MAX_LEN (FIELD_MAX_LEN)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (buf_clr),
    .wr_en     (buf_wr),
    .wr_slot   (slot_q),
    .wr_char   (bus.in_char),
    .publish   (pub_d),
    .pub_dat   (bus.fields_vec),
    .pub_len   (bus.fields_len),
    .pub_trunc (bus.trunc_flags),
    .pub_vld   (bus.sent_valid)
  );

  assign bus.sent_count = sent_count_q;
`ifdef NMEA_CKSUM_EN
  assign bus.err_cksum = err_cksum_q;
`else
  assign bus.err_cksum = 1'b0;
`endif

endmodule

// File: doc/nmea_sentence_parser.md
Name: nmea_sentence_parser

Overview:
Generalised NMEA-0183 sentence parser. Sits between uart_rx and ascii_to_fixed/formatter.
- Accepts one sentence type (any talker), selected by parameter.
- Captures up to NUM_SLOTS comma-separated fields, selected at run time by a mask.
- Verifies the '*hh' checksum and publishes all captured fields atomically on a one-cycle strobe.

Parameters:
- TYPE_ID, "RMC": 3-char sentence type matched at address chars 3..5. Talker chars 1..2 are ignored.
- NUM_SLOTS, 4: number of capture slots.
- FIELD_MAX_LEN, 16: maximum characters stored per slot.
- MAX_CHARS, 82: maximum characters from '$' to '\r' inclusive.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_char  in  8  received byte.
- in_valid  in  1  in_char qualifier, one-cycle pulse per byte.
- field_mask  in  32  bit i set = capture field i. Field 0 is the address field; field 1 is the first field after it. Sampled at '$'.
- fields_vec  out  NUM_SLOTS*FIELD_MAX_LEN*8  captured characters. Slot s, char j is at [(s*FIELD_MAX_LEN+j)*8 +: 8]. j=0 is the first character received. Unused chars are 0.
- fields_len  out  NUM_SLOTS*8  character count per slot.
- trunc_flags  out  NUM_SLOTS  slot overflowed FIELD_MAX_LEN.
- sent_valid  out  1  one-cycle pulse: new sentence published.
- err_cksum  out  1  one-cycle pulse: checksum mismatch or malformed checksum.
- sent_count  out  16  accepted-sentence counter; wraps at 0xFFFF to 0.

Behaviour:
- Reset: all outputs 0, state IDLE, working buffers cleared. Reset mid-sentence discards the sentence with no pulse.
- Per-byte work is done only in cycles with in_valid=1. All outputs are registered.
- Double buffering:
  - The working buffer fills during the sentence.
  - The published registers (fields_vec/len/trunc_flags) update only together with sent_valid.
  - Published registers hold until the next sent_valid.
- States:
  - IDLE: wait for '$'. On '$': clear working buffer, cksum=0, field index=0, slot pointer=0, char count=1, latch field_mask. Go to ADDR.
  - ADDR: 5 chars, XORed into cksum. Chars 3..5 are compared with TYPE_ID. At the following ',': mismatch → IDLE silently; match → FIELDS.
  - FIELDS:
    - ',' increments the field index; if the closed field was masked, advance the slot pointer.
    - Other chars are stored into the current slot only if the field is masked and the slot pointer < NUM_SLOTS.
    - A char beyond FIELD_MAX_LEN is dropped and sets that slot's trunc flag.
    - Masked fields beyond NUM_SLOTS are ignored.
    - All chars except '*' are XORed into cksum.
    - '*' → CK_HI.
    - '\r' with no '*' → treated as a checksum error.
  - CK_HI / CK_LO: one hex digit each, 0-9 / A-F / a-f. A non-hex char → err_cksum pulse, go to IDLE. Then → WAIT_CR.
  - WAIT_CR: on '\r', compare the received value with cksum.
    - Equal: sent_valid pulse the next cycle, publish buffers, sent_count+1.
    - Else: err_cksum pulse, no publish.
    - Go to IDLE. '\n' is ignored in IDLE.
- '$' in any non-IDLE state aborts the current sentence (no pulse) and restarts as at IDLE.
- Char count exceeding MAX_CHARS → silent drop to IDLE.
- Field 0 capture stores the 5 address chars.
- sent_valid and err_cksum are never asserted in the same cycle.

Optional Feature:
NMEA_CKSUM_EN.
- Defined: checksum verification as above.
- Undefined:
  - CK_HI/CK_LO are skipped; chars after '*' are ignored until '\r'.
  - '\r' always publishes, whether or not a '*' was seen.
  - err_cksum is tied to 0.
  - The cksum register is removed.

Decomposition:
- Package nmea_pkg: ASCII constants ('$', ',', '*', CR, LF), state encoding, and a hex-char-to-nibble function with a valid flag.
- Sub-module nmea_field_buffer: working and published slot storage, write pointer, length, trunc flags, publish strobe.
- The parser FSM and checksum stay in the top module.

Test Plan:
- "$GPRMC,1,A*3B\r\n", mask=0x6 → one sent_valid; slot0="1" len1; slot1="A" len1; slots 2-3 len0; sent_count=1.
- "$GPRMC,1,A*3C\r\n" → err_cksum pulse, no sent_valid, published registers unchanged, sent_count unchanged.
- FIELD_MAX_LEN=12, field 3="4807.038123456" (correct checksum) → slot0 len12 "4807.0381234", trunc_flags[0]=1.
- "$GPGGA,1,A*..." → no pulses. "$GPRMC,12$GPRMC,1,A*3B\r\n" → exactly one sent_valid with slot0="1".
- rst asserted after "$GPRMC,1" then released, then full valid sentence → one sent_valid, sent_count=1; no pulse for the aborted sentence.
- NMEA_CKSUM_EN undefined: "$GPRMC,1,A*3C\r\n" → sent_valid, err_cksum stays 0.
